rx_ts_parser: RTL and testbench
===============================

# rx_ts_parser

Gen1/Gen2 receive-side training-sequence parser that directly consumes the descrambler output (data, K flags, valid) on each lane. It hunts for COM, collects the 16 symbols of a TS1/TS2 ordered set across 1, 2 or 4 symbols per cycle, and validates them. It then publishes the decoded fields plus a consecutive-identical-TS count to the LTSSM. It is idle when GEN ≥ 3.

## Interface
Parameters:
- TS_LEN, 16, symbols per training sequence.
- CNT_W, 4, width of consecutive-TS counter (saturating).

Ports:
- clk  in  1  PIPE clock.
- reset  in  1  synchronous, active-high reset.
- descramblerDataValid  in  1  symbols on this cycle are valid.
- descramblerData  in  32  descrambled symbols; symbol 0 is [7:0] and is first in time.
- descramblerDataK  in  4  per-symbol K flag.
- PIPEWIDTH  in  6  8/16/32; gives 1/2/4 symbols per cycle.
- GEN  in  3  current generation.
- tsValid  out  1  one-cycle pulse: a well-formed TS completed.
- tsType  out  1  0=TS1, 1=TS2.
- tsLinkNum / tsLaneNum  out  8 each  symbols 1 and 2.
- tsLinkPad / tsLanePad  out  1 each  symbol 1 / symbol 2 was PAD (K, 0xF7).
- tsNFts / tsRateId / tsTrainCtrl  out  8 each  symbols 3, 4, 5.
- tsConsecCount  out  CNT_W  consecutive identical TSs, including this one.
- tsError  out  1  one-cycle pulse: a TS in progress was aborted.

## Operation
- Symbols consumed per valid cycle: PIPEWIDTH 8 → slot 0; 16 → slots 0–1; 32 → slots 0–3. Other widths, descramblerDataValid=0, or GEN≥3 → no symbols consumed and state held. GEN≥3 additionally forces the state to HUNT, with no pulses.
- The state is idx ∈ {HUNT, 1..15}. Slots are processed strictly in order, chained within the cycle.
- HUNT: K=1 and 0xBC (COM) → idx=1. Anything else → stay.
- idx 1, 2: accept K=0 data, or K=1 0xF7 (records the PAD flag).
- idx 3–5: require K=0.
- idx 6: require K=0 and 0x4A (TS1) or 0x45 (TS2); latch the type/ID.
- idx 7–15: require K=0 and a value equal to the latched ID.
- Failure at any idx:
  - abort and set tsError;
  - the consecutive count is cleared and the previous-TS record invalidated;
  - if the offending symbol is COM → idx=1 (re-sync in place), else HUNT.
- Success at idx 15:
  - capture the fields and go to HUNT;
  - a COM later in the same cycle starts a new TS.
- Consecutive count, on success:
  - if the previous record is valid and type plus symbols 1–5 (including PAD flags) are identical → count+1, saturating at 2^CNT_W−1;
  - else count=1;
  - the record is then updated.
- At most one success per cycle (4 < 16). Abort and success in the same cycle is possible (abort, COM re-sync, then no completion); tsError and tsValid are independent.
- Field outputs hold their last value between pulses.

## Timing
- Every output is registered. tsValid/tsError assert the cycle after the clock edge at which symbol 15 / the offending symbol was presented, for exactly one cycle.
- Reset: idx=HUNT, record invalid, every output 0. Reset mid-TS discards partial data with no tsError.
- PIPEWIDTH or GEN changing mid-TS needs no special handling, except that GEN≥3 forces HUNT silently.
- Valid=0 gaps mid-TS are transparent: the parse resumes on the next valid symbol.

## Structure
- Package rx_ts_pkg: COM_SYM=8'hBC, PAD_SYM=8'hF7, TS1_ID=8'h4A, TS2_ID=8'h45, TS_LEN, idx encoding (HUNT=0), and a packed ts_fields_t (type, link, lane, pads, nFts, rateId, trainCtrl).
- Sub-module ts_symbol_step: purely combinational, one symbol. Inputs: idx, latched fields, symbol, K. Outputs: next idx, updated fields, done, abort. It is instantiated 4× and chained; slot enable comes from PIPEWIDTH.
- Top level holds the idx/field registers, the previous-TS record, the counter, and the output registers.

## Test plan
- Width 8, one TS1 with link=0x01, lane=0x00, nFts=0x80, rate=0x02, ctrl=0x00, all K=0 except COM → one tsValid 16 valid cycles after COM; tsType=0, fields as sent, tsConsecCount=1.
- Width 32, 8 back-to-back identical TS2s with link/lane PAD (0xF7, K=1) → tsValid every 4th cycle; tsType=1, both pad flags=1, counts 1..8. Then 20 more → count saturates at 15.
- Width 16, TS1 with symbol 9 = 0x45 → tsError one cycle later, no tsValid, count=0. The next good TS1 → count=1.
- COM arriving at idx 4 (width 32, slot 2) → tsError; the new TS parses from that COM, and a correct tsValid follows.
- Width 8 with descramblerDataValid=0 inserted every other cycle → the same fields as the gap-free case, with tsValid delayed accordingly.
- Reset asserted at idx 10; GEN=3 while TSs are streaming → no tsValid/tsError, all outputs 0 after reset.

Source files
------------

// File: rtl/rx_ts_parser_pkg.sv
// rx_ts_pkg: training-sequence symbol constants, parse index encoding and decoded TS field record
package rx_ts_pkg;
  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] PAD_SYM = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  localparam int TS_LEN = 16;
  typedef logic [3:0] idx_t;
  localparam idx_t HUNT = 4'd0;
  localparam idx_t LAST_IDX = idx_t'(TS_LEN - 1);
  typedef struct packed {
    logic ts_type;
    logic [7:0] link;
    logic [7:0] lane;
    logic link_pad;
    logic lane_pad;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctrl;
  } ts_fields_t;
  function automatic logic [7:0] id_of(input logic ts_type);
    return ts_type ? TS2_ID : TS1_ID;
  endfunction
endpackage

// File: rtl/rx_ts_parser_if.sv
// rx_ts_parser_if: descrambler symbol stream in (master drives), decoded TS fields/pulses out (slave drives)
interface rx_ts_parser_if #(parameter int CNT_W = 4);
  logic descramblerDataValid;
  logic [31:0] descramblerData;
  logic [3:0] descramblerDataK;
  logic [5:0] PIPEWIDTH;
  logic [2:0] GEN;
  logic tsValid;
  logic tsType;
  logic [7:0] tsLinkNum;
  logic [7:0] tsLaneNum;
  logic tsLinkPad;
  logic tsLanePad;
  logic [7:0] tsNFts;
  logic [7:0] tsRateId;
  logic [7:0] tsTrainCtrl;
  logic [CNT_W-1:0] tsConsecCount;
  logic tsError;
  modport master (
    output descramblerDataValid, descramblerData, descramblerDataK, PIPEWIDTH, GEN,
    input tsValid, tsType, tsLinkNum, tsLaneNum, tsLinkPad, tsLanePad, tsNFts, tsRateId,
    tsTrainCtrl, tsConsecCount, tsError
  );
  modport slave (
    input descramblerDataValid, descramblerData, descramblerDataK, PIPEWIDTH, GEN,
    output tsValid, tsType, tsLinkNum, tsLaneNum, tsLinkPad, tsLanePad, tsNFts, tsRateId,
    tsTrainCtrl, tsConsecCount, tsError
  );
endinterface

// File: rtl/rx_ts_parser_step.sv
// ts_symbol_step: one-symbol TS parse step (en, idx, fin, sym, k in; idx_nxt, fout, done, abort out)
module ts_symbol_step import rx_ts_pkg::*; #(
  parameter idx_t LAST = LAST_IDX
) (
  input logic en,
  input idx_t idx,
  input ts_fields_t fin,
  input logic [7:0] sym,
  input logic k,
  output idx_t idx_nxt,
  output ts_fields_t fout,
  output logic done,
  output logic abort
);
  logic is_com;
  logic ok;
  always_comb begin
    is_com = k && sym == COM_SYM;
    ok = (idx == 4'd1 || idx == 4'd2) ? (!k || sym == PAD_SYM) :
         (idx >= 4'd3 && idx <= 4'd5) ? !k :
         idx == 4'd6 ? !k && (sym == TS1_ID || sym == TS2_ID) :
         !k && sym == id_of(fin.ts_type);
    fout = fin;
    idx_nxt = idx;
    done = 1'b0;
    abort = 1'b0;
    if (en) begin
      if (idx == HUNT) begin
        idx_nxt = is_com ? 4'd1 : HUNT;
      end else if (!ok) begin
        abort = 1'b1;
        idx_nxt = is_com ? 4'd1 : HUNT;
      end else begin
        done = idx == LAST;
        idx_nxt = done ? HUNT : idx + 4'd1;
        case (idx)
          4'd1: begin fout.link = sym; fout.link_pad = k; end
          4'd2: begin fout.lane = sym; fout.lane_pad = k; end
          4'd3: fout.n_fts = sym;
          4'd4: fout.rate_id = sym;
          4'd5: fout.train_ctrl = sym;
          4'd6: fout.ts_type = sym == TS2_ID;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/rx_ts_parser.sv
// rx_ts_parser: Gen1/2 TS1/TS2 parser (clk, reset, bus: descrambler symbols in, decoded fields/count/pulses out)
module rx_ts_parser #(
  parameter int TS_LEN = 16,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  rx_ts_parser_if.slave bus
);
  import rx_ts_pkg::*;
  idx_t idx_q, idx_1, idx_2, idx_3, idx_4;
  ts_fields_t fld_q, fld_1, fld_2, fld_3, fld_4, done_f, rec_q, out_f;
  logic [3:0] en, done, abort;
  logic act, rec_v, ts_valid, ts_error;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  always_comb begin
    act = bus.descramblerDataValid && bus.GEN < 3'd3;
    en = !act ? 4'b0000 :
         bus.PIPEWIDTH == 6'd8 ? 4'b0001 :
         bus.PIPEWIDTH == 6'd16 ? 4'b0011 :
         bus.PIPEWIDTH == 6'd32 ? 4'b1111 : 4'b0000;
    done_f = done[0] ? fld_1 : done[1] ? fld_2 : done[2] ? fld_3 : fld_4;
    cnt_nxt = !(rec_v && rec_q == done_f) ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  end
  ts_symbol_step #(.LAST(idx_t'(TS_LEN - 1))) u_step0 (
    .en(en[0]), .idx(idx_q), .fin(fld_q), .sym(bus.descramblerData[7:0]),
    .k(bus.descramblerDataK[0]), .idx_nxt(idx_1), .fout(fld_1), .done(done[0]), .abort(abort[0])
  );
  ts_symbol_step #(.LAST(idx_t'(TS_LEN - 1))) u_step1 (
    .en(en[1]), .idx(idx_1), .fin(fld_1), .sym(bus.descramblerData[15:8]),
    .k(bus.descramblerDataK[1]), .idx_nxt(idx_2), .fout(fld_2), .done(done[1]), .abort(abort[1])
  );
  ts_symbol_step #(.LAST(idx_t'(TS_LEN - 1))) u_step2 (
    .en(en[2]), .idx(idx_2), .fin(fld_2), .sym(bus.descramblerData[23:16]),
    .k(bus.descramblerDataK[2]), .idx_nxt(idx_3), .fout(fld_3), .done(done[2]), .abort(abort[2])
  );
  ts_symbol_step #(.LAST(idx_t'(TS_LEN - 1))) u_step3 (
    .en(en[3]), .idx(idx_3), .fin(fld_3), .sym(bus.descramblerData[31:24]),
    .k(bus.descramblerDataK[3]), .idx_nxt(idx_4), .fout(fld_4), .done(done[3]), .abort(abort[3])
  );
  // An abort can only follow a completion within a cycle (a restart cannot reach the last index
  // in the remaining slots), so abort taking priority for the count/record is the in-order result.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= HUNT;
      fld_q <= '0;
      rec_q <= '0;
      rec_v <= 1'b0;
      cnt_q <= '0;
      out_f <= '0;
      ts_valid <= 1'b0;
      ts_error <= 1'b0;
    end else if (bus.GEN >= 3'd3) begin
      idx_q <= HUNT;
      ts_valid <= 1'b0;
      ts_error <= 1'b0;
    end else begin
      idx_q <= idx_4;
      fld_q <= fld_4;
      ts_valid <= |done;
      ts_error <= |abort;
      if (|done) out_f <= done_f;
      if (|abort) begin
        rec_v <= 1'b0;
        cnt_q <= '0;
      end else if (|done) begin
        rec_v <= 1'b1;
        rec_q <= done_f;
        cnt_q <= cnt_nxt;
      end
    end
  end
  assign bus.tsValid = ts_valid;
  assign bus.tsError = ts_error;
  assign bus.tsType = out_f.ts_type;
  assign bus.tsLinkNum = out_f.link;
  assign bus.tsLaneNum = out_f.lane;
  assign bus.tsLinkPad = out_f.link_pad;
  assign bus.tsLanePad = out_f.lane_pad;
  assign bus.tsNFts = out_f.n_fts;
  assign bus.tsRateId = out_f.rate_id;
  assign bus.tsTrainCtrl = out_f.train_ctrl;
  assign bus.tsConsecCount = cnt_q;
endmodule

// File: tb/tb_rx_ts_parser.sv
// tb_rx_ts_parser: scoreboard bench for rx_ts_parser with directed TS streams
module tb_rx_ts_parser;
  import rx_ts_pkg::*;
  typedef struct {
    logic [7:0] d;
    logic k;
    bit ev_v;
    bit ev_e;
    int cnt;
    ts_fields_t f;
  } sym_t;
  typedef struct {
    int cyc;
    bit v;
    bit e;
    int cnt;
    ts_fields_t f;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  sym_t sq[$];
  sym_t tail[$];
  exp_t sb[$];
  ts_fields_t f1, f2;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  rx_ts_parser_if #(.CNT_W(4)) bus ();
  rx_ts_parser #(.TS_LEN(16), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " tsValid"}, 64'(bus.tsValid), 0);
    chk({tag, " tsError"}, 64'(bus.tsError), 0);
    chk({tag, " tsType"}, 64'(bus.tsType), 0);
    chk({tag, " tsLinkNum"}, 64'(bus.tsLinkNum), 0);
    chk({tag, " tsLaneNum"}, 64'(bus.tsLaneNum), 0);
    chk({tag, " pads"}, 64'({bus.tsLinkPad, bus.tsLanePad}), 0);
    chk({tag, " tsNFts"}, 64'(bus.tsNFts), 0);
    chk({tag, " tsRateId"}, 64'(bus.tsRateId), 0);
    chk({tag, " tsTrainCtrl"}, 64'(bus.tsTrainCtrl), 0);
    chk({tag, " tsConsecCount"}, 64'(bus.tsConsecCount), 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bus.tsValid || bus.tsError)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected event: tsValid=%b tsError=%b at cycle %0d", bus.tsValid, bus.tsError, cyc);
      end else begin
        e = sb.pop_front();
        chk("event cycle", 64'(cyc), 64'(e.cyc));
        chk("tsValid", 64'(bus.tsValid), 64'(e.v));
        chk("tsError", 64'(bus.tsError), 64'(e.e));
        chk("tsConsecCount", 64'(bus.tsConsecCount), 64'(e.cnt));
        if (e.v) begin
          chk("tsType", 64'(bus.tsType), 64'(e.f.ts_type));
          chk("tsLinkNum", 64'(bus.tsLinkNum), 64'(e.f.link));
          chk("tsLaneNum", 64'(bus.tsLaneNum), 64'(e.f.lane));
          chk("tsLinkPad", 64'(bus.tsLinkPad), 64'(e.f.link_pad));
          chk("tsLanePad", 64'(bus.tsLanePad), 64'(e.f.lane_pad));
          chk("tsNFts", 64'(bus.tsNFts), 64'(e.f.n_fts));
          chk("tsRateId", 64'(bus.tsRateId), 64'(e.f.rate_id));
          chk("tsTrainCtrl", 64'(bus.tsTrainCtrl), 64'(e.f.train_ctrl));
        end
      end
    end
  end
  task automatic add_sym(input logic [7:0] d, input logic k);
    sym_t s;
    s.d = d;
    s.k = k;
    s.ev_v = 0;
    s.ev_e = 0;
    s.cnt = 0;
    s.f = '0;
    sq.push_back(s);
  endtask
  task automatic add_ts(input ts_fields_t f, input int cnt, input bit mark, input int bad_i, input logic [7:0] bad_d);
    for (int i = 0; i < 16; i++) begin
      sym_t s;
      s.ev_v = 0;
      s.ev_e = 0;
      s.cnt = cnt;
      s.f = f;
      s.k = 1'b0;
      case (i)
        0: begin s.d = COM_SYM; s.k = 1'b1; end
        1: begin s.d = f.link; s.k = f.link_pad; end
        2: begin s.d = f.lane; s.k = f.lane_pad; end
        3: s.d = f.n_fts;
        4: s.d = f.rate_id;
        5: s.d = f.train_ctrl;
        default: s.d = f.ts_type ? 8'h45 : 8'h4A;
      endcase
      if (i == bad_i) begin
        s.d = bad_d;
        s.ev_e = 1;
      end else if (i == 15 && mark && bad_i < 0) begin
        s.ev_v = 1;
      end
      sq.push_back(s);
    end
  endtask
  task automatic run(input int w, input bit gap);
    int n = w / 8;
    while (sq.size() > 0) begin
      exp_t e;
      sym_t s;
      logic [31:0] d = 32'hBCBC_BCBC;
      logic [3:0] k = 4'hF;
      e.cyc = 0;
      e.v = 0;
      e.e = 0;
      e.cnt = 0;
      e.f = '0;
      for (int i = 0; i < n; i++) begin
        if (sq.size() > 0) s = sq.pop_front();
        else begin
          s.d = 8'h00;
          s.k = 1'b0;
          s.ev_v = 0;
          s.ev_e = 0;
          s.cnt = 0;
          s.f = '0;
        end
        d[8*i+:8] = s.d;
        k[i] = s.k;
        if (s.ev_v) begin
          e.v = 1;
          e.f = s.f;
          e.cnt = s.cnt;
        end
        if (s.ev_e) e.e = 1;
      end
      @(posedge clk);
      #1;
      bus.descramblerData = d;
      bus.descramblerDataK = k;
      bus.descramblerDataValid = 1'b1;
      bus.PIPEWIDTH = 6'(w);
      if (e.v || e.e) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      if (gap) begin
        @(posedge clk);
        #1;
        bus.descramblerDataValid = 1'b0;
        bus.descramblerData = 32'hBCBC_BCBC;
        bus.descramblerDataK = 4'hF;
      end
    end
    @(posedge clk);
    #1;
    bus.descramblerDataValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.descramblerDataValid = 1'b0;
    bus.descramblerData = '0;
    bus.descramblerDataK = '0;
    bus.PIPEWIDTH = 6'd8;
    bus.GEN = 3'd2;
    f1 = '{ts_type: 1'b0, link: 8'h01, lane: 8'h00, link_pad: 1'b0, lane_pad: 1'b0,
           n_fts: 8'h80, rate_id: 8'h02, train_ctrl: 8'h00};
    f2 = '{ts_type: 1'b1, link: 8'hF7, lane: 8'hF7, link_pad: 1'b1, lane_pad: 1'b1,
           n_fts: 8'h1F, rate_id: 8'h02, train_ctrl: 8'h00};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("initial reset");
    add_ts(f1, 1, 1, -1, 8'h00);
    run(8, 0);
    for (int i = 0; i < 28; i++) add_ts(f2, (i + 1 > 15) ? 15 : i + 1, 1, -1, 8'h00);
    run(32, 0);
    add_ts(f1, 0, 0, 9, 8'h45);
    add_ts(f1, 1, 1, -1, 8'h00);
    run(16, 0);
    add_sym(8'h00, 1'b0);
    add_sym(8'h00, 1'b0);
    add_sym(COM_SYM, 1'b1);
    add_sym(8'h01, 1'b0);
    add_sym(8'h00, 1'b0);
    add_sym(8'h80, 1'b0);
    add_ts(f1, 1, 1, -1, 8'h00);
    sq[6].ev_e = 1;
    run(32, 0);
    add_ts(f1, 2, 1, -1, 8'h00);
    run(8, 1);
    add_ts(f1, 0, 0, -1, 8'h00);
    tail = sq[10:15];
    sq = sq[0:9];
    run(8, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("mid-TS reset");
    sq = tail;
    run(8, 0);
    bus.GEN = 3'd3;
    for (int i = 0; i < 3; i++) add_ts(f2, 0, 0, -1, 8'h00);
    run(32, 0);
    bus.GEN = 3'd2;
    add_ts(f1, 1, 1, -1, 8'h00);
    run(8, 0);
    repeat (5) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing event: expected at cycle %0d valid=%b error=%b", e.cyc, e.v, e.e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
